// File: rtl/mrd_fsm_ctrl_p2.sv
// Stage sequencer for a mixed-radix DFT engine: sink a frame, run N read/write-back stages, then source.
// Optional watchdog on the Rd / Wait_wr_end states is enabled with `define MRD_FSM_TIMEOUT_EN.
module mrd_fsm_ctrl_p2 #(
  parameter int unsigned WAIT_RD    = 4,
  parameter int unsigned MAX_STAGES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [11:0] dftpts,
  input  logic [2:0]  num_stages,
  input  logic        rd_end,
  input  logic        wr_end,
  input  logic        source_end,
  output logic [2:0]  fsm,
  output logic [2:0]  fsm_r,
  output logic [2:0]  stage_idx,
  output logic        stage_start,
  output logic        sink_ready,
  output logic [11:0] dftpts_lat,
  output logic        err_len,
  output logic        err_proto,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SINK    = 3'd1,
    S_WAIT_RD = 3'd2,
    S_RD      = 3'd3,
    S_WAIT_WR = 3'd4,
    S_SOURCE  = 3'd5
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_RD - 1);
  localparam logic [2:0] MAX_ST    = 3'(MAX_STAGES);

  state_e      state_q, state_d, state_nxt_s;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  stages_q, stages_d;
  logic [2:0]  fsm_r_q, fsm_r_d;
  logic [2:0]  stage_idx_q, stage_idx_d;
  logic        stage_start_q, stage_start_d;
  logic        sink_ready_q, sink_ready_d;
  logic [11:0] dftpts_lat_q, dftpts_lat_d;
  logic        err_len_q, err_len_d;
  logic        err_proto_q, err_proto_d;
  logic        sop_ok_s, last_stage_s, timeout_s;
  logic [11:0] beat_s;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    logic [11:0] r;
    if (v == 12'hFFF) r = v;
    else              r = v + 12'd1;
    return r;
  endfunction

  function automatic logic [2:0] clamp_stages(input logic [2:0] n);
    logic [2:0] r;
    if (n == 3'd0)        r = 3'd1;
    else if (n > MAX_ST)  r = MAX_ST;
    else                  r = n;
    return r;
  endfunction

  // Frame start is only honoured while the block advertises ready
  assign sop_ok_s     = sink_valid & sink_sop & sink_ready_q;
  assign last_stage_s = (stage_idx_q == (stages_q - 3'd1));
  assign beat_s       = sat_inc(cnt_q);

`ifdef MRD_FSM_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_timeout_q, err_timeout_d;

  // Fires on the last cycle of a stall that received no completion pulse
  assign timeout_s   = (((state_q == S_RD) && !rd_end) || ((state_q == S_WAIT_WR) && !wr_end)) &&
                       (wd_q == 16'hFFFE);
  assign err_timeout = err_timeout_q;

  always_comb begin
    wd_d          = 16'd0;
    err_timeout_d = err_timeout_q;
    if (!rst_n) begin
      wd_d          = 16'd0;
      err_timeout_d = 1'b0;
    end else begin
      if (((state_q == S_RD) || (state_q == S_WAIT_WR)) && (state_d == state_q)) wd_d = wd_q + 16'd1;
      else                                                                       wd_d = 16'd0;
      err_timeout_d = err_timeout_q | timeout_s;
    end
  end

  always_ff @(posedge clk) begin
    wd_q          <= wd_d;
    err_timeout_q <= err_timeout_d;
  end
`else
  assign timeout_s   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_nxt_s = state_q;
    case (state_q)
      S_IDLE: begin
        if (sop_ok_s) state_nxt_s = sink_eop ? S_WAIT_RD : S_SINK;
        else          state_nxt_s = S_IDLE;
      end
      S_SINK: begin
        if (sink_valid && sink_eop) state_nxt_s = S_WAIT_RD;
        else                        state_nxt_s = S_SINK;
      end
      S_WAIT_RD: begin
        if (wait_cnt_q == WAIT_LAST) state_nxt_s = S_RD;
        else                         state_nxt_s = S_WAIT_RD;
      end
      S_RD: begin
        if (rd_end) state_nxt_s = S_WAIT_WR;
        else        state_nxt_s = S_RD;
      end
      S_WAIT_WR: begin
        if (wr_end) state_nxt_s = last_stage_s ? S_SOURCE : S_WAIT_RD;
        else        state_nxt_s = S_WAIT_WR;
      end
      S_SOURCE: begin
        if (source_end) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_SOURCE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
    if (!rst_n || timeout_s) state_d = S_IDLE;
    else                     state_d = state_nxt_s;
  end

  always_comb begin
    fsm_r_d       = fsm_r_q;
    stage_start_d = stage_start_q;
    sink_ready_d  = sink_ready_q;
    wait_cnt_d    = wait_cnt_q;
    cnt_d         = cnt_q;
    stages_d      = stages_q;
    stage_idx_d   = stage_idx_q;
    dftpts_lat_d  = dftpts_lat_q;
    err_len_d     = err_len_q;
    err_proto_d   = err_proto_q;
    if (!rst_n) begin
      fsm_r_d       = 3'd0;
      stage_start_d = 1'b0;
      sink_ready_d  = 1'b0;
      wait_cnt_d    = 4'd0;
      cnt_d         = 12'd0;
      stages_d      = 3'd0;
      stage_idx_d   = 3'd0;
      dftpts_lat_d  = 12'd0;
      err_len_d     = 1'b0;
      err_proto_d   = 1'b0;
    end else begin
      fsm_r_d       = state_q;
      stage_start_d = (state_d == S_RD) && (state_q != S_RD);
      sink_ready_d  = (state_d == S_IDLE) || (state_d == S_SINK);
      // Any other state holds the counter at zero, so it starts clean on entry
      wait_cnt_d    = (state_q == S_WAIT_RD) ? (wait_cnt_q + 4'd1) : 4'd0;
      err_proto_d   = err_proto_q | (sink_valid & ~sink_ready_q);
      case (state_q)
        S_IDLE: begin
          if (sop_ok_s) begin
            dftpts_lat_d = dftpts;
            stages_d     = clamp_stages(num_stages);
            cnt_d        = 12'd1;
            stage_idx_d  = 3'd0;
            err_len_d    = err_len_q | (sink_eop & (dftpts != 12'd1));
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_SINK: begin
          if (sink_valid) begin
            cnt_d       = beat_s;
            err_proto_d = err_proto_q | sink_sop;
            err_len_d   = err_len_q | (sink_eop & (beat_s != dftpts_lat_q));
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_WAIT_WR: begin
          if (wr_end && !last_stage_s) stage_idx_d = stage_idx_q + 3'd1;
          else                         stage_idx_d = stage_idx_q;
        end
        S_SOURCE: begin
          if (source_end) stage_idx_d = 3'd0;
          else            stage_idx_d = stage_idx_q;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
      if (timeout_s) stage_idx_d = 3'd0;
      else           stage_idx_d = stage_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    fsm_r_q       <= fsm_r_d;
    stage_start_q <= stage_start_d;
    sink_ready_q  <= sink_ready_d;
    wait_cnt_q    <= wait_cnt_d;
    cnt_q         <= cnt_d;
    stages_q      <= stages_d;
    stage_idx_q   <= stage_idx_d;
    dftpts_lat_q  <= dftpts_lat_d;
    err_len_q     <= err_len_d;
    err_proto_q   <= err_proto_d;
  end

  assign fsm         = state_q;
  assign fsm_r       = fsm_r_q;
  assign stage_idx   = stage_idx_q;
  assign stage_start = stage_start_q;
  assign sink_ready  = sink_ready_q;
  assign dftpts_lat  = dftpts_lat_q;
  assign err_len     = err_len_q;
  assign err_proto   = err_proto_q;

endmodule

// File: doc/mrd_fsm_ctrl_p2.md
MRD_FSM_CTRL_P2 -- requirements
Module: mrd_fsm_ctrl_p2

Interface
REQ-001 Parameter WAIT_RD, default 4: idle cycles spent in Wait_to_rd before each read stage (range 1..15).
REQ-002 Parameter MAX_STAGES, default 6: maximum number of butterfly stages per DFT.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sink_valid  input  1  input sample valid.
REQ-006 sink_sop  input  1  first sample of a frame; qualified by sink_valid.
REQ-007 sink_eop  input  1  last sample of a frame; qualified by sink_valid.
REQ-008 dftpts  input  12  DFT length; sampled at frame start.
REQ-009 num_stages  input  3  stage count; sampled at frame start; 0 is treated as 1; values above MAX_STAGES are clamped to MAX_STAGES.
REQ-010 rd_end  input  1  one-cycle pulse from the read path: current stage's reads are issued.
REQ-011 wr_end  input  1  one-cycle pulse from the write-back path: current stage's writes are complete.
REQ-012 source_end  input  1  one-cycle pulse from the source generator: output frame is done.
REQ-013 fsm  output  3  current state: Idle=0, Sink=1, Wait_to_rd=2, Rd=3, Wait_wr_end=4, Source=5.
REQ-014 fsm_r  output  3  fsm delayed by one cycle.
REQ-015 stage_idx  output  3  current butterfly stage, 0-based.
REQ-016 stage_start  output  1  one-cycle pulse on the first cycle of each Rd visit.
REQ-017 sink_ready  output  1  high only in Idle and Sink.
REQ-018 dftpts_lat  output  12  DFT length latched at frame start.
REQ-019 err_len  output  1  sticky flag: a frame's sample count did not equal dftpts_lat.
REQ-020 err_proto  output  1  sticky flag: protocol violation (see REQ-030).

Function
REQ-021 Idle -> Sink when sink_valid&sink_sop; in the same cycle, latch dftpts and num_stages, set the sample count to 1, and set stage_idx=0.
REQ-022 Sink: sample count increments on each sink_valid; sink_valid&sink_eop -> Wait_to_rd on the next cycle.
REQ-023 At eop, set err_len if the sample count including the eop sample is not equal to dftpts_lat; the sample counter is 12 bits and saturates at 4095, no wrap.
REQ-024 A single-sample frame (sop and eop on the same beat) goes Idle -> Wait_to_rd directly.
REQ-025 Wait_to_rd: a wait counter clears on entry and leaves for Rd after exactly WAIT_RD cycles in the state; stage_start is high on that first Rd cycle.
REQ-026 Rd -> Wait_wr_end on rd_end.
REQ-027 Wait_wr_end on wr_end:
  - if stage_idx == latched num_stages-1: go to Source;
  - otherwise: increment stage_idx and go to Wait_to_rd.
REQ-028 Source -> Idle on source_end; stage_idx clears to 0.
REQ-029 rd_end, wr_end and source_end are ignored outside Rd, Wait_wr_end and Source respectively.
REQ-030 Set err_proto on any of:
  - sink_valid&sink_sop while in Sink (the sop is counted as data; the frame continues);
  - sink_valid while sink_ready=0 (the sample is dropped).
REQ-031 If rd_end and wr_end are high together in Rd, only rd_end acts.
REQ-032 All outputs are registered; fsm changes one cycle after the qualifying input edge.
REQ-033 err_len and err_proto clear only on reset.

Reset
REQ-034 While rst_n=0 at a clock edge, all outputs go to 0 (fsm=Idle, fsm_r=0, sink_ready=0) and all counters clear.
REQ-035 On the first cycle after rst_n=1, sink_ready=1.
REQ-036 Reset asserted mid-frame aborts the frame; no pending pulse is remembered.

Configuration
REQ-037 MRD_FSM_TIMEOUT_EN defined:
  - a 16-bit watchdog runs in Rd and Wait_wr_end and clears on each state change;
  - at 65535 it forces Idle, sets sticky output err_timeout, and clears stage_idx.
REQ-038 MRD_FSM_TIMEOUT_EN undefined: no watchdog; err_timeout is tied to 0; Rd and Wait_wr_end wait indefinitely.

Verification
REQ-039 dftpts=12, num_stages=2, 12-beat frame, each rd_end/wr_end 20 cycles after stage_start -> fsm sequence 0,1,2,3,4,2,3,4,5,0; stage_idx 0 then 1; two stage_start pulses; err_len=0.
REQ-040 dftpts=12, frame with eop on beat 10 -> err_len=1 after eop; sequencing otherwise unchanged.
REQ-041 num_stages=0 -> exactly one Rd visit, then Source.
REQ-042 sink_valid pulse during Rd -> err_proto=1, fsm unchanged; wr_end pulse during Rd -> ignored.
REQ-043 rst_n=0 for 1 cycle during Wait_wr_end at stage 1 -> next cycle fsm=0, stage_idx=0, flags 0, sink_ready=1 once rst_n=1.
REQ-044 With MRD_FSM_TIMEOUT_EN defined, no wr_end after Rd -> Idle and err_timeout=1 exactly 65535 cycles after entering Wait_wr_end.
